// File: rtl/regression_accumulator_pkg.sv
// Shared types and sizing for the regression accumulator.
// Holds the width macro, default geometry and FSM encoding.
`ifndef REGRESSION_ACCUMULATOR_BITS
`define REGRESSION_ACCUMULATOR_BITS
`define BITS(x) $clog2(x)
`endif

package regression_accumulator_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int WORD_COUNT = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADR_X = 3'd1,
    ADR_Y = 3'd2,
    ACC   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // At most wc/2 points, so that many guard bits above a full product.
  function automatic int acc_width(
    input int ws,
    input int wc
  );
    return 2 * ws + `BITS(wc / 2);
  endfunction

endpackage

// File: rtl/regression_accumulator_if.sv
// Control, memory read port and result bundle of the accumulator.
// master is the accumulator side, slave the caller/memory side.
interface regression_accumulator_if
  import regression_accumulator_pkg::*;
#(
  parameter int WordSize  = WORD_SIZE,
  parameter int WordCount = WORD_COUNT
);

  localparam int AdrWidth = `BITS(WordCount);
  localparam int AccWidth = acc_width(WordSize, WordCount);

  logic                       start;
  logic [AdrWidth-1:0]        count;
  logic [WordSize-1:0]        memData;
  logic [AdrWidth-1:0]        memAdr;
  logic                       busy;
  logic                       done;
  logic signed [AccWidth-1:0] sumX;
  logic signed [AccWidth-1:0] sumY;
  logic signed [AccWidth-1:0] sumXY;
  logic signed [AccWidth-1:0] sumXX;

  modport master (
    input  start,
    input  count,
    input  memData,
    output memAdr,
    output busy,
    output done,
    output sumX,
    output sumY,
    output sumXY,
    output sumXX
  );

  modport slave (
    output start,
    output count,
    output memData,
    input  memAdr,
    input  busy,
    input  done,
    input  sumX,
    input  sumY,
    input  sumXY,
    input  sumXX
  );

endinterface

// File: rtl/regression_mac.sv
// Combinational signed multiply-accumulate: sum = acc + a*b.
// The full-width product is sign-extended onto the accumulator.
module regression_mac
  import regression_accumulator_pkg::*;
#(
  parameter int WordSize = WORD_SIZE,
  parameter int AccWidth = acc_width(WORD_SIZE, WORD_COUNT)
) (
  input  logic signed [WordSize-1:0] a,
  input  logic signed [WordSize-1:0] b,
  input  logic signed [AccWidth-1:0] acc,
  output logic signed [AccWidth-1:0] sum
);

  localparam int ProdWidth = 2 * WordSize;
  localparam int ExtWidth  = AccWidth - ProdWidth;

  logic signed [ProdWidth-1:0] prod;
  logic signed [AccWidth-1:0]  prod_ext;

  always_comb begin
    prod     = a * b;
    prod_ext = {{ExtWidth{prod[ProdWidth-1]}}, prod};
    sum      = acc + prod_ext;
  end

endmodule

// File: rtl/regression_accumulator.sv
// Walks N (x,y) pairs through a 1-cycle read port and accumulates
// sumX, sumY, sumXY and sumXX for the slope/intercept stage.
module regression_accumulator
  import regression_accumulator_pkg::*;
#(
  parameter int WordSize  = WORD_SIZE,
  parameter int WordCount = WORD_COUNT
) (
  input logic clk,
  input logic rst,
  regression_accumulator_if.master bus
);

  localparam int AdrWidth = `BITS(WordCount);
  localparam int AccWidth = acc_width(WordSize, WordCount);
  localparam int ExtWidth = AccWidth - WordSize;
  localparam logic [AdrWidth-1:0] MaxPoints =
    AdrWidth'(WordCount / 2);

  state_t state;

  logic [AdrWidth-1:0] n;
  logic [AdrWidth-1:0] i;
  logic [AdrWidth-1:0] i_inc;
  logic [AdrWidth-1:0] n_last;
  logic [AdrWidth-1:0] n_start;

  logic signed [WordSize-1:0] x_reg;
  logic signed [WordSize-1:0] y;

  logic signed [AccWidth-1:0] x_ext;
  logic signed [AccWidth-1:0] y_ext;
  logic signed [AccWidth-1:0] xy_next;
  logic signed [AccWidth-1:0] xx_next;

  always_comb begin
    y       = bus.memData;
    x_ext   = {{ExtWidth{x_reg[WordSize-1]}}, x_reg};
    y_ext   = {{ExtWidth{y[WordSize-1]}}, y};
    i_inc   = i + AdrWidth'(1);
    n_last  = n - AdrWidth'(1);
    n_start = (bus.count > MaxPoints) ? MaxPoints : bus.count;
  end

  regression_mac #(
    .WordSize (WordSize),
    .AccWidth (AccWidth)
  ) u_mac_xy (
    .a   (x_reg),
    .b   (y),
    .acc (bus.sumXY),
    .sum (xy_next)
  );

  regression_mac #(
    .WordSize (WordSize),
    .AccWidth (AccWidth)
  ) u_mac_xx (
    .a   (x_reg),
    .b   (x_reg),
    .acc (bus.sumXX),
    .sum (xx_next)
  );

  // memAdr is loaded one state early so the read data lands on time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      n          <= '0;
      i          <= '0;
      x_reg      <= '0;
      bus.memAdr <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.sumX   <= '0;
      bus.sumY   <= '0;
      bus.sumXY  <= '0;
      bus.sumXX  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (state == DONE && !bus.done) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
          if (bus.start) begin
            n         <= n_start;
            i         <= '0;
            bus.done  <= 1'b0;
            bus.busy  <= 1'b1;
            bus.sumX  <= '0;
            bus.sumY  <= '0;
            bus.sumXY <= '0;
            bus.sumXX <= '0;
            if (n_start == '0) begin
              state <= DONE;
            end else begin
              state      <= ADR_X;
              bus.memAdr <= '0;
            end
          end
        end
        ADR_X: begin
          bus.memAdr <= {i[AdrWidth-2:0], 1'b1};
          state      <= ADR_Y;
        end
        ADR_Y: begin
          x_reg <= bus.memData;
          state <= ACC;
        end
        ACC: begin
          bus.sumX  <= bus.sumX + x_ext;
          bus.sumY  <= bus.sumY + y_ext;
          bus.sumXY <= xy_next;
          bus.sumXX <= xx_next;
          if (i == n_last) begin
            state <= DONE;
          end else begin
            i          <= i_inc;
            bus.memAdr <= {i_inc[AdrWidth-2:0], 1'b0};
            state      <= ADR_X;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
